// File: rtl/pipe_stall_ctrl_if.sv
// Handshake bundle between the pipeline stages and the central stall controller.
// The controller uses the slave modport; the pipeline side uses master.
interface pipe_stall_ctrl_if #(
    parameter int CNT_W  = 6,
    parameter int PERF_W = 32
);
    logic              stallreq_id;
    logic              stallreq_ex;
    logic              mc_start;
    logic [CNT_W-1:0]  mc_cycles;
    logic              mc_cancel;
    logic              perf_clr;
    logic [5:0]        stall;
    logic              mc_busy;
    logic              mc_done;
    logic [PERF_W-1:0] stall_cnt;

    modport slave (
        input  stallreq_id, stallreq_ex, mc_start, mc_cycles, mc_cancel, perf_clr,
        output stall, mc_busy, mc_done, stall_cnt
    );

    modport master (
        output stallreq_id, stallreq_ex, mc_start, mc_cycles, mc_cancel, perf_clr,
        input  stall, mc_busy, mc_done, stall_cnt
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central 5-stage pipeline stall controller: arbitrates ID/EX stall requests,
// sequences multi-cycle EX ops and counts stalled cycles (saturating).
module pipe_stall_ctrl #(
    parameter int CNT_W  = 6,
    parameter int PERF_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    pipe_stall_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_NONE = 6'b000000;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, done_q;
    logic [PERF_W-1:0]  perf_q, perf_d;
    logic               start_ok;
    logic [CNT_W-1:0]   n_eff;
    logic [5:0]         stall_d;

    // A zero length still occupies EX for one cycle.
    assign n_eff    = (bus.mc_cycles == '0) ? CNT_W'(1) : bus.mc_cycles;
    assign start_ok = bus.mc_start && !bus.mc_cancel && (state_q != RUN);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (bus.mc_cancel) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                if (start_ok) begin
                    if (n_eff == CNT_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                        cnt_d   = n_eff - CNT_W'(1);
                    end
                end
            end
        endcase
    end

    // Reset is folded in so the stall vector clears without waiting for a clock.
    always_comb begin
        stall_d = STALL_NONE;
        if (!rst || bus.mc_cancel)    stall_d = STALL_NONE;
        else if (state_q == RUN)      stall_d = STALL_EX;
        else if (start_ok)            stall_d = STALL_EX;
        else if (bus.stallreq_ex)     stall_d = STALL_EX;
        else if (bus.stallreq_id)     stall_d = STALL_ID;
    end

    always_comb begin
        perf_d = perf_q;
        if (bus.perf_clr)                      perf_d = '0;
        else if (stall_d[0] && perf_q != '1)   perf_d = perf_q + PERF_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            perf_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == RUN);
            done_q  <= (state_d == DONE);
            perf_q  <= perf_d;
        end
    end

    assign bus.stall     = stall_d;
    assign bus.mc_busy   = busy_q;
    assign bus.mc_done   = done_q;
    assign bus.stall_cnt = perf_q;
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: arbitration, multi-cycle sequencing,
// cancel/reset behaviour and the saturating stall counter (narrow second instance).
module tb_pipe_stall_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   ecnt     = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl_if #(.CNT_W(6), .PERF_W(32)) b0 ();
    pipe_stall_ctrl_if #(.CNT_W(6), .PERF_W(4))  b1 ();

    pipe_stall_ctrl #(.CNT_W(6), .PERF_W(32)) u0 (.clk(clk), .rst(rst), .bus(b0));
    pipe_stall_ctrl #(.CNT_W(6), .PERF_W(4))  u1 (.clk(clk), .rst(rst), .bus(b1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic id, input logic ex, input logic st,
                          input logic [5:0] n, input logic cn, input logic clr);
        b0.stallreq_id = id;
        b0.stallreq_ex = ex;
        b0.mc_start    = st;
        b0.mc_cycles   = n;
        b0.mc_cancel   = cn;
        b0.perf_clr    = clr;
    endtask

    // One clock cycle on the main instance: check at negedge, then advance.
    task automatic cyc(input string tag, input logic [5:0] es, input logic eb, input logic ed);
        @(negedge clk);
        $display("%0t %s stall=%b busy=%b done=%b cnt=%0d", $time, tag,
                 b0.stall, b0.mc_busy, b0.mc_done, b0.stall_cnt);
        chk({tag, ".stall"}, {26'd0, b0.stall}, {26'd0, es});
        chk({tag, ".busy"},  {31'd0, b0.mc_busy}, {31'd0, eb});
        chk({tag, ".done"},  {31'd0, b0.mc_done}, {31'd0, ed});
        chk({tag, ".cnt"},   b0.stall_cnt, ecnt);
        if (b0.perf_clr) ecnt = 0;
        else if (es[0])  ecnt++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        set_in(1'b0, 1'b1, 1'b1, 6'd3, 1'b0, 1'b0);
        b1.stallreq_id = 1'b0; b1.stallreq_ex = 1'b1; b1.mc_start = 1'b0;
        b1.mc_cycles = 6'd0;   b1.mc_cancel = 1'b0;   b1.perf_clr = 1'b0;
        #3;
        chk("rst.stall", {26'd0, b0.stall}, 32'd0);
        chk("rst.busy",  {31'd0, b0.mc_busy}, 32'd0);
        chk("rst.done",  {31'd0, b0.mc_done}, 32'd0);
        chk("rst.cnt",   b0.stall_cnt, 32'd0);
        chk("rst.cnt1",  {28'd0, b1.stall_cnt}, 32'd0);
        @(posedge clk); #1;
        cyc("rst_hold", 6'b000000, 1'b0, 1'b0);
        rst = 1'b1;

        set_in(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0); cyc("id_req",  6'b000111, 1'b0, 1'b0);
        set_in(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0); cyc("idle",    6'b000000, 1'b0, 1'b0);
        set_in(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0); cyc("arb",     6'b001111, 1'b0, 1'b0);
        set_in(1'b1, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0); cyc("arb_cn",  6'b000000, 1'b0, 1'b0);
        set_in(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0); cyc("idle2",   6'b000000, 1'b0, 1'b0);

        set_in(1'b0, 1'b0, 1'b1, 6'd4, 1'b0, 1'b0); cyc("n4_t0",   6'b001111, 1'b0, 1'b0);
        set_in(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        for (int i = 1; i < 4; i++) cyc("n4_run", 6'b001111, 1'b1, 1'b0);
        cyc("n4_done", 6'b000000, 1'b0, 1'b1);
        cyc("n4_idle", 6'b000000, 1'b0, 1'b0);

        set_in(1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0); cyc("n0_t0",   6'b001111, 1'b0, 1'b0);
        set_in(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0); cyc("n0_done", 6'b000000, 1'b0, 1'b1);
        cyc("n0_idle", 6'b000000, 1'b0, 1'b0);
        set_in(1'b0, 1'b0, 1'b1, 6'd1, 1'b0, 1'b0); cyc("n1_t0",   6'b001111, 1'b0, 1'b0);
        set_in(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0); cyc("n1_done", 6'b000111, 1'b0, 1'b1);
        set_in(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0); cyc("n1_idle", 6'b000000, 1'b0, 1'b0);

        set_in(1'b0, 1'b0, 1'b1, 6'd1, 1'b0, 1'b0); cyc("b2b_t0",  6'b001111, 1'b0, 1'b0);
        set_in(1'b0, 1'b0, 1'b1, 6'd2, 1'b0, 1'b0); cyc("b2b_d1",  6'b001111, 1'b0, 1'b1);
        set_in(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0); cyc("b2b_run", 6'b001111, 1'b1, 1'b0);
        cyc("b2b_d2",  6'b000000, 1'b0, 1'b1);
        cyc("b2b_idl", 6'b000000, 1'b0, 1'b0);

        set_in(1'b0, 1'b0, 1'b1, 6'd3, 1'b0, 1'b0); cyc("ign_t0",  6'b001111, 1'b0, 1'b0);
        set_in(1'b0, 1'b0, 1'b1, 6'd5, 1'b0, 1'b0); cyc("ign_r1",  6'b001111, 1'b1, 1'b0);
        cyc("ign_r2",  6'b001111, 1'b1, 1'b0);
        set_in(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0); cyc("ign_dn",  6'b000000, 1'b0, 1'b1);
        cyc("ign_idl", 6'b000000, 1'b0, 1'b0);

        set_in(1'b0, 1'b0, 1'b1, 6'd8, 1'b0, 1'b0); cyc("cn_t0",   6'b001111, 1'b0, 1'b0);
        set_in(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        cyc("cn_t1", 6'b001111, 1'b1, 1'b0);
        cyc("cn_t2", 6'b001111, 1'b1, 1'b0);
        set_in(1'b0, 1'b1, 1'b1, 6'd2, 1'b1, 1'b0); cyc("cn_t3",   6'b000000, 1'b1, 1'b0);
        set_in(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        for (int i = 4; i < 10; i++) cyc("cn_after", 6'b000000, 1'b0, 1'b0);

        set_in(1'b0, 1'b0, 1'b1, 6'd8, 1'b0, 1'b0); cyc("rr_t0",   6'b001111, 1'b0, 1'b0);
        set_in(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0); cyc("rr_t1",   6'b001111, 1'b1, 1'b0);
        chk("rr_pre.busy", {31'd0, b0.mc_busy}, 32'd1);
        rst = 1'b0;
        #1;
        $display("%0t rst_mid stall=%b busy=%b done=%b cnt=%0d", $time,
                 b0.stall, b0.mc_busy, b0.mc_done, b0.stall_cnt);
        chk("rr.stall", {26'd0, b0.stall}, 32'd0);
        chk("rr.busy",  {31'd0, b0.mc_busy}, 32'd0);
        chk("rr.done",  {31'd0, b0.mc_done}, 32'd0);
        chk("rr.cnt",   b0.stall_cnt, 32'd0);
        ecnt = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 9; i++) cyc("rr_after", 6'b000000, 1'b0, 1'b0);

        set_in(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0); cyc("pc_id",   6'b000111, 1'b0, 1'b0);
        set_in(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1); cyc("pc_clr",  6'b000111, 1'b0, 1'b0);
        set_in(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0); cyc("pc_zero", 6'b000000, 1'b0, 1'b0);

        // Narrow instance has held stallreq_ex since reset release; force a clean start.
        b1.perf_clr = 1'b1;
        @(posedge clk); #1;
        b1.perf_clr = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        $display("%0t sat stall=%b cnt=%0d", $time, b1.stall, b1.stall_cnt);
        chk("sat.stall", {26'd0, b1.stall}, {26'd0, 6'b001111});
        chk("sat.full",  {28'd0, b1.stall_cnt}, 32'hF);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            $display("%0t sat_hold cnt=%0d", $time, b1.stall_cnt);
            chk("sat.hold", {28'd0, b1.stall_cnt}, 32'hF);
        end
        b1.perf_clr = 1'b1;
        @(posedge clk); #1;
        b1.perf_clr = 1'b0;
        @(negedge clk);
        $display("%0t sat_clr cnt=%0d", $time, b1.stall_cnt);
        chk("sat.clr", {28'd0, b1.stall_cnt}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("sat.restart", {28'd0, b1.stall_cnt}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central stall controller for the 5-stage pipeline.
- Produces the 6-bit stall vector that holds or bubbles the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Arbitrates the one-cycle stall requests from ID (load-use) and EX.
- Sequences multi-cycle EX operations (madd/msub/div) with an internal counter and state machine, and keeps a saturating stall-cycle performance counter.

Parameters:
CNT_W, 6, width of mc_cycles and of the internal countdown register.
PERF_W, 32, width of the stall-cycle performance counter.

Ports:
clk  in  1  pipeline clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
stallreq_id  in  1  ID stage stall request (load-use), level, same-cycle effect
stallreq_ex  in  1  EX stage stall request, level, same-cycle effect
mc_start  in  1  EX begins a multi-cycle op this cycle
mc_cycles  in  CNT_W  total EX occupancy in cycles for the op, sampled with mc_start
mc_cancel  in  1  flush: abort any multi-cycle op
perf_clr  in  1  synchronous clear of stall_cnt
stall  out  6  [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB; 1 = hold that stage
mc_busy  out  1  registered; 1 while state==RUN
mc_done  out  1  registered; one-cycle pulse, state==DONE
stall_cnt  out  PERF_W  count of cycles with stall[0]==1

Behaviour:
- Reset (rst==0, asynchronous): state=IDLE, countdown=0, stall_cnt=0. mc_busy=0, mc_done=0, and stall=6'b000000 immediately, independent of clk.
- States: IDLE, RUN, DONE; 2-bit state register.
- Stall encodings, combinational from inputs and state:
  - EX hold = 6'b001111 (PC, IF, ID, EX held; EX/MEM receives a bubble).
  - ID hold = 6'b000111 (EX continues; ID/EX receives a bubble).
  - none = 6'b000000.
- Stall priority, highest first:
  1. mc_cancel → none.
  2. state==RUN → EX hold.
  3. mc_start accepted this cycle → EX hold.
  4. stallreq_ex → EX hold.
  5. stallreq_id → ID hold.
  6. otherwise none.
- mc_start is accepted only in IDLE or DONE, and only when mc_cancel==0.
  - mc_start in RUN is ignored.
  - Effective length N = mc_cycles, with mc_cycles==0 treated as N=1.
- Transitions:
  - IDLE/DONE, accepted start:
    - N==1 → DONE.
    - N>1 → RUN, countdown<=N-1.
  - IDLE/DONE, no start → IDLE. DONE therefore lasts exactly one cycle unless a back-to-back start is accepted, which goes to RUN or DONE as above.
  - RUN, mc_cancel → IDLE; no mc_done is produced.
  - RUN, countdown==1 → DONE.
  - RUN, otherwise → countdown<=countdown-1.
- Resulting timing for start in cycle t:
  - stall = EX hold in cycles t..t+N-1 (exactly N cycles).
  - mc_done=1 and stall released in cycle t+N.
  - mc_busy=1 in cycles t+1..t+N-1.
- In DONE, stall follows the stallreq_ex/stallreq_id arbitration; the pipeline advances unless a request or a new start holds it.
- mc_cancel in IDLE or DONE: forces stall=none that cycle, next state IDLE, and suppresses any mc_start that cycle.
- stall_cnt:
  - perf_clr has priority → 0 next edge.
  - Otherwise +1 on each edge where stall[0]==1.
  - Saturates at all-ones (no wrap).
- Reset mid-RUN: the op is abandoned, no mc_done is produced, and all outputs return to reset values asynchronously.
- No combinational path from mc_done or mc_busy back to stall inputs.

Test Plan:
- Reset: hold rst=0 with stallreq_ex=1 and mc_start=1 → stall=000000, mc_busy=0, mc_done=0, stall_cnt=0. Release rst, pulse stallreq_id for 1 cycle → stall=000111 that cycle, stall_cnt=1.
- Arbitration: stallreq_id=1 and stallreq_ex=1 together → stall=001111. Add mc_cancel=1 → stall=000000.
- Multi-cycle N=4: mc_start at cycle 10 with mc_cycles=4 →
  - stall=001111 in cycles 10..13
  - mc_busy=1 in cycles 11..13
  - mc_done=1 only in cycle 14, stall=000000 in cycle 14
  - stall_cnt +4
- Edge lengths and back-to-back:
  - mc_cycles=0 and mc_cycles=1 → one stalled cycle, mc_done the next cycle, mc_busy never 1.
  - New mc_start=1 (N=2) during the DONE cycle → RUN, stall in that cycle and the next, second mc_done two cycles later.
  - mc_start asserted again during RUN → ignored; original done timing unchanged.
- Cancel and reset: N=8 started at cycle 0.
  - mc_cancel at cycle 3 → stall=000000 in cycle 3, IDLE at cycle 4, no mc_done.
  - Repeat with rst=0 mid-RUN → outputs clear without a clock edge.
- Perf counter: preload via forced stall until stall_cnt=FFFFFFFF, stall 3 more cycles → stays FFFFFFFF. perf_clr=1 together with stall → 0 next edge.
